chan_event_counter_array: RTL and testbench
===========================================

CHAN_EVENT_COUNTER_ARRAY -- requirements
Module: chan_event_counter_array

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning number of independent event channels (1..32).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning counter width per channel (2..32).
REQ-003 The block SHALL have parameter SATURATE, default 0, meaning 0 = counters wrap at max, 1 = counters hold at max.
REQ-004 The block SHALL have parameter CLR_ON_RD, default 0, meaning 1 = a channel is cleared when its read request is accepted.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 The block SHALL have port ev_i, input, NCH, meaning per-channel event pulse, one count per high cycle.
REQ-008 The block SHALL have port clr_i, input, NCH, meaning per-channel clear of count and overflow flag.
REQ-009 The block SHALL have port rd_valid_i, input, 1, meaning read request valid.
REQ-010 The block SHALL have port rd_sel_i, input, max(1,$clog2(NCH)), meaning channel index of the read request.
REQ-011 The block SHALL have port rd_ready_o, output, 1, meaning the block can accept a read request.
REQ-012 The block SHALL have port rsp_valid_o, input/output pairing as follows: rsp_valid_o output 1, rsp_ready_i input 1, rsp_data_o output WIDTH, rsp_ovf_o output 1, rsp_err_o output 1, meaning response handshake, snapshot count, snapshot overflow flag, and bad-index error.
REQ-013 The block SHALL have port nonzero_o, output, NCH, meaning per-channel count != 0, and any_ovf_o, output, 1, meaning OR of all overflow flags.

Function
REQ-014 Each channel SHALL increment its count by 1 in every cycle in which ev_i[k]=1 and no clear applies.
REQ-015 Clear priority SHALL be: rst > clr_i[k] / clear-on-read > ev_i[k]; an event coincident with a clear SHALL be dropped (count = 0 next cycle).
REQ-016 With SATURATE=0, an event at count 2^WIDTH-1 SHALL give count 0 and set the channel overflow flag.
REQ-017 With SATURATE=1, an event at count 2^WIDTH-1 SHALL leave the count at max and set the overflow flag.
REQ-018 The overflow flag SHALL be sticky until a clear of that channel or rst.
REQ-019 The read path SHALL use a two-state FSM: IDLE (rd_ready_o=1, rsp_valid_o=0) and RESP (rd_ready_o=0, rsp_valid_o=1).
REQ-020 In IDLE, rd_valid_i=1 SHALL accept the request, capture the count and flag of channel rd_sel_i as they are before that edge's update, and enter RESP; response latency SHALL be 1 cycle.
REQ-021 In RESP, rsp_data_o/rsp_ovf_o/rsp_err_o SHALL be stable until rsp_ready_i=1, which returns the FSM to IDLE; no back-to-back acceptance in the same cycle.
REQ-022 rd_sel_i >= NCH SHALL be accepted, give rsp_err_o=1, rsp_data_o=0, rsp_ovf_o=0, and affect no channel.
REQ-023 With CLR_ON_RD=1, the selected valid channel SHALL be cleared on the acceptance edge; an event that same cycle SHALL be dropped per REQ-015.
REQ-024 nonzero_o and any_ovf_o SHALL be combinational from the registered channel state.

Reset
REQ-025 With rst=1 at a rising edge, all counts SHALL be 0, all overflow flags 0, FSM IDLE; therefore rd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_ovf_o=0, rsp_err_o=0, nonzero_o=0, any_ovf_o=0.
REQ-026 rst asserted while in RESP SHALL discard the pending response without requiring rsp_ready_i.

Structure
REQ-027 Package chan_event_counter_pkg SHALL hold the read FSM state enum and the channel-index width function.
REQ-028 Channels SHALL be instantiated by a generate loop of sub-module chan_counter (count, overflow, saturate/wrap), one per channel.

Verification
REQ-029 WIDTH=4, SATURATE=0: 17 events on ch0 -> count 1, rsp_ovf_o=1 on read, any_ovf_o=1.
REQ-030 WIDTH=4, SATURATE=1: 20 events on ch1 -> read gives 15, ovf 1; clr_i[1] -> read gives 0, ovf 0.
REQ-031 ev_i[2] and clr_i[2] high the same cycle at count 5 -> next read of ch2 gives 0.
REQ-032 Read ch3 (count 7) with rsp_ready_i held low 10 cycles while ch3 gets 3 more events -> rsp_data_o stays 7; next read gives 10.
REQ-033 CLR_ON_RD=1: read ch0 at count 9 with an event on the acceptance cycle -> response 9, later read 0; NCH=3, rd_sel_i=3 -> rsp_err_o=1, data 0.
REQ-034 rst pulsed during RESP -> rsp_valid_o=0, rd_ready_o=1, all counts 0 next cycle.

Source files
------------

// File: rtl/chan_event_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chan_event_counter_pkg
// Description : Shared types and helpers for the channel event counter array:
//               read-path FSM state encoding and channel-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package chan_event_counter_pkg;

  // Read-path states: IDLE accepts a request, RESP holds the response
  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  // Width of a channel index; at least one bit even for a single channel
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/chan_event_counter_array_chan_counter.sv
`default_nettype none
// ============================================================================
// Module      : chan_counter
// Description : One event channel: counter with sticky overflow flag, either
//               wrapping or saturating at its maximum value. Clear beats event.
// Revision    : 1.0 - initial release
// ============================================================================
module chan_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] C_MAX = '1;

  // Count events; a clear in the same cycle drops the event
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (ev) begin
      if (count == C_MAX) begin
        ovf   <= 1'b1;
        count <= SATURATE ? C_MAX : '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/chan_event_counter_array.sv
`default_nettype none
// ============================================================================
// Module      : chan_event_counter_array
// Description : NCH independent event counters with a valid/ready read port.
//               A read snapshots one channel's count and overflow flag; an
//               out-of-range index returns an error response and touches
//               nothing. Optional clear-on-read of the selected channel.
// Revision    : 1.0 - initial release
// ============================================================================
module chan_event_counter_array
  import chan_event_counter_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int WIDTH     = 8,
  parameter bit SATURATE  = 1'b0,
  parameter bit CLR_ON_RD = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NCH-1:0]                ev_i,
  input  logic [NCH-1:0]                clr_i,
  input  logic                          rd_valid_i,
  input  logic [sel_width(NCH)-1:0]     rd_sel_i,
  output logic                          rd_ready_o,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [WIDTH-1:0]              rsp_data_o,
  output logic                          rsp_ovf_o,
  output logic                          rsp_err_o,
  output logic [NCH-1:0]                nonzero_o,
  output logic                          any_ovf_o
);

  localparam int SELW = sel_width(NCH);

  rd_state_t                  state;
  logic [NCH-1:0][WIDTH-1:0]  counts;
  logic [NCH-1:0]             ovfs;
  logic                       accept;
  logic                       sel_ok;
  logic [WIDTH-1:0]           sel_count;
  logic                       sel_ovf;

  assign accept = (state == RD_IDLE) && rd_valid_i;
  assign sel_ok = 32'(rd_sel_i) < 32'(NCH);

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_chan
      logic chan_clr;
      // Explicit clear, or clear-on-read when this channel's read is accepted
      assign chan_clr = clr_i[k] |
                        (CLR_ON_RD && accept && (rd_sel_i == SELW'(k)));

      chan_counter #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
      ) u_chan (
        .clk   (clk),
        .rst   (rst),
        .ev    (ev_i[k]),
        .clr   (chan_clr),
        .count (counts[k]),
        .ovf   (ovfs[k])
      );

      assign nonzero_o[k] = |counts[k];
    end
  endgenerate

  assign any_ovf_o = |ovfs;

  // Select the addressed channel's pre-update state; zero for a bad index
  always_comb begin
    sel_count = '0;
    sel_ovf   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_sel_i == SELW'(k)) begin
        sel_count = counts[k];
        sel_ovf   = ovfs[k];
      end
    end
  end

  // Read FSM: capture on acceptance, hold response until it is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RD_IDLE;
      rsp_data_o <= '0;
      rsp_ovf_o  <= 1'b0;
      rsp_err_o  <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (rd_valid_i) begin
            rsp_data_o <= sel_count;
            rsp_ovf_o  <= sel_ovf;
            rsp_err_o  <= ~sel_ok;
            state      <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (rsp_ready_i) state <= RD_IDLE;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  assign rd_ready_o  = (state == RD_IDLE);
  assign rsp_valid_o = (state == RD_RESP);

endmodule
`default_nettype wire

// File: tb/tb_chan_event_counter_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_chan_event_counter_array
// Description : Self-checking bench with three configurations of the counter
//               array: A wrap (4ch, 4b), B saturate (4ch, 4b), C clear-on-read
//               (3ch, 4b). Shared clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chan_event_counter_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ev        [3];
  logic [3:0] clr       [3];
  logic       rd_valid  [3];
  logic [1:0] rd_sel    [3];
  logic       rsp_ready [3];
  logic       rd_ready  [3];
  logic       rsp_valid [3];
  logic [3:0] rsp_data  [3];
  logic       rsp_ovf   [3];
  logic       rsp_err   [3];
  logic       any_ovf   [3];
  logic [3:0] nz_a, nz_b;
  logic [2:0] nz_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chan_event_counter_array #(.NCH(4), .WIDTH(4), .SATURATE(1'b0), .CLR_ON_RD(1'b0)) dut_a (
    .clk(clk), .rst(rst), .ev_i(ev[0]), .clr_i(clr[0]),
    .rd_valid_i(rd_valid[0]), .rd_sel_i(rd_sel[0]), .rd_ready_o(rd_ready[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_data_o(rsp_data[0]),
    .rsp_ovf_o(rsp_ovf[0]), .rsp_err_o(rsp_err[0]), .nonzero_o(nz_a), .any_ovf_o(any_ovf[0]));

  chan_event_counter_array #(.NCH(4), .WIDTH(4), .SATURATE(1'b1), .CLR_ON_RD(1'b0)) dut_b (
    .clk(clk), .rst(rst), .ev_i(ev[1]), .clr_i(clr[1]),
    .rd_valid_i(rd_valid[1]), .rd_sel_i(rd_sel[1]), .rd_ready_o(rd_ready[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_data_o(rsp_data[1]),
    .rsp_ovf_o(rsp_ovf[1]), .rsp_err_o(rsp_err[1]), .nonzero_o(nz_b), .any_ovf_o(any_ovf[1]));

  chan_event_counter_array #(.NCH(3), .WIDTH(4), .SATURATE(1'b0), .CLR_ON_RD(1'b1)) dut_c (
    .clk(clk), .rst(rst), .ev_i(ev[2][2:0]), .clr_i(clr[2][2:0]),
    .rd_valid_i(rd_valid[2]), .rd_sel_i(rd_sel[2]), .rd_ready_o(rd_ready[2]),
    .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]), .rsp_data_o(rsp_data[2]),
    .rsp_ovf_o(rsp_ovf[2]), .rsp_err_o(rsp_err[2]), .nonzero_o(nz_c), .any_ovf_o(any_ovf[2]));

  typedef struct {
    logic [3:0] ev;
    logic [3:0] clr;
    logic [3:0] exp_nz;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_ev(input int u, input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      ev[u][ch] = 1'b1;
      tick();
    end
    ev[u][ch] = 1'b0;
  endtask

  task automatic clear_ch(input int u, input int ch);
    clr[u][ch] = 1'b1;
    tick();
    clr[u][ch] = 1'b0;
  endtask

  task automatic do_read(input int u, input int sel,
                         output logic [3:0] d, output logic o, output logic e);
    int n;
    n = 0;
    while (!rd_ready[u] && n < 20) begin
      tick();
      n++;
    end
    chk("rd_ready_wait", 32'(rd_ready[u]), 32'd1);
    rd_valid[u] = 1'b1;
    rd_sel[u]   = 2'(sel);
    tick();
    rd_valid[u] = 1'b0;
    chk("rsp_valid_latency", 32'(rsp_valid[u]), 32'd1);
    d = rsp_data[u];
    o = rsp_ovf[u];
    e = rsp_err[u];
    rsp_ready[u] = 1'b1;
    tick();
    rsp_ready[u] = 1'b0;
  endtask

  initial begin
    logic [3:0] d;
    logic       o, e;

    tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 1'b0};
    tbl[1] = '{4'b0110, 4'b0000, 4'b0111, 1'b0};
    tbl[2] = '{4'b1000, 4'b0001, 4'b1110, 1'b0};
    tbl[3] = '{4'b0010, 4'b0010, 4'b1100, 1'b0};
    tbl[4] = '{4'b0000, 4'b1100, 4'b0000, 1'b0};
    tbl[5] = '{4'b1111, 4'b0000, 4'b1111, 1'b0};
    tbl[6] = '{4'b0000, 4'b1111, 4'b0000, 1'b0};

    for (int u = 0; u < 3; u++) begin
      ev[u] = '0; clr[u] = '0; rd_valid[u] = 1'b0; rd_sel[u] = '0; rsp_ready[u] = 1'b0;
    end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state of all three units
    for (int u = 0; u < 3; u++) begin
      chk("reset_rd_ready", 32'(rd_ready[u]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid[u]), 32'd0);
      chk("reset_rsp_data", 32'(rsp_data[u]), 32'd0);
      chk("reset_any_ovf", 32'(any_ovf[u]), 32'd0);
    end
    chk("reset_nz_a", 32'(nz_a), 32'd0);
    chk("reset_nz_c", 32'(nz_c), 32'd0);

    // Table: per-cycle event/clear patterns on unit A
    for (int i = 0; i < 7; i++) begin
      ev[0]  = tbl[i].ev;
      clr[0] = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_nonzero", i), 32'(nz_a), 32'(tbl[i].exp_nz));
      chk($sformatf("tbl%0d_any_ovf", i), 32'(any_ovf[0]), 32'(tbl[i].exp_ovf));
    end
    ev[0] = '0; clr[0] = '0;

    // Wrap: 17 events on ch0 -> count 1 with overflow
    pulse_ev(0, 0, 17);
    chk("wrap_any_ovf", 32'(any_ovf[0]), 32'd1);
    do_read(0, 0, d, o, e);
    chk("wrap_data", 32'(d), 32'd1);
    chk("wrap_ovf", 32'(o), 32'd1);
    chk("wrap_err", 32'(e), 32'd0);

    // Saturate: 20 events on ch1 -> 15 with overflow; clear -> 0, no overflow
    pulse_ev(1, 1, 20);
    do_read(1, 1, d, o, e);
    chk("sat_data", 32'(d), 32'd15);
    chk("sat_ovf", 32'(o), 32'd1);
    clear_ch(1, 1);
    do_read(1, 1, d, o, e);
    chk("sat_clr_data", 32'(d), 32'd0);
    chk("sat_clr_ovf", 32'(o), 32'd0);
    chk("sat_clr_any_ovf", 32'(any_ovf[1]), 32'd0);

    // Event coincident with clear at count 5 is dropped
    pulse_ev(0, 2, 5);
    ev[0][2] = 1'b1; clr[0][2] = 1'b1;
    tick();
    ev[0][2] = 1'b0; clr[0][2] = 1'b0;
    do_read(0, 2, d, o, e);
    chk("evclr_data", 32'(d), 32'd0);

    // Held response stays stable while the channel keeps counting
    clear_ch(0, 3);
    pulse_ev(0, 3, 7);
    rd_valid[0] = 1'b1; rd_sel[0] = 2'd3;
    tick();
    rd_valid[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ev[0][3] = (i < 3);
      chk($sformatf("hold%0d_valid", i), 32'(rsp_valid[0]), 32'd1);
      chk($sformatf("hold%0d_data", i), 32'(rsp_data[0]), 32'd7);
      tick();
    end
    ev[0][3] = 1'b0;
    chk("hold_ready_low", 32'(rd_ready[0]), 32'd0);
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    chk("hold_release_idle", 32'(rd_ready[0]), 32'd1);
    do_read(0, 3, d, o, e);
    chk("hold_next_data", 32'(d), 32'd10);

    // Clear-on-read with a coincident event
    pulse_ev(2, 0, 9);
    rd_valid[2] = 1'b1; rd_sel[2] = 2'd0; ev[2][0] = 1'b1;
    tick();
    rd_valid[2] = 1'b0; ev[2][0] = 1'b0;
    chk("cor_data", 32'(rsp_data[2]), 32'd9);
    chk("cor_nz_after", 32'(nz_c[0]), 32'd0);
    rsp_ready[2] = 1'b1;
    tick();
    rsp_ready[2] = 1'b0;
    do_read(2, 0, d, o, e);
    chk("cor_later_data", 32'(d), 32'd0);

    // Out-of-range index: error response, no channel affected
    pulse_ev(2, 1, 2);
    do_read(2, 3, d, o, e);
    chk("badidx_err", 32'(e), 32'd1);
    chk("badidx_data", 32'(d), 32'd0);
    chk("badidx_ovf", 32'(o), 32'd0);
    chk("badidx_nz", 32'(nz_c), 32'b010);
    do_read(2, 1, d, o, e);
    chk("badidx_ch1_kept", 32'(d), 32'd2);
    chk("goodidx_err", 32'(e), 32'd0);

    // Reset while a response is pending
    pulse_ev(0, 1, 3);
    rd_valid[0] = 1'b1; rd_sel[0] = 2'd1;
    tick();
    rd_valid[0] = 1'b0;
    chk("rstresp_pending", 32'(rsp_valid[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstresp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rstresp_ready", 32'(rd_ready[0]), 32'd1);
    chk("rstresp_data", 32'(rsp_data[0]), 32'd0);
    chk("rstresp_nz_a", 32'(nz_a), 32'd0);
    chk("rstresp_any_ovf", 32'(any_ovf[0]), 32'd0);
    chk("rstresp_nz_c", 32'(nz_c), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
